// File: rtl/matrix_frame_scheduler.sv
// Shares one LED-matrix frame serializer between two requesters: arbitration, inter-frame gap,
// frame timeout/abort and completed-frame counting. Define MATRIX_SCHED_FIXED_PRIO_EN for fixed priority.
module matrix_frame_scheduler #(
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int FCNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    output logic [1:0]        grant,
    output logic [1:0]        req_done,
    output logic              ser_start,
    input  logic              ser_done,
    output logic              ser_abort,
    output logic              err_timeout,
    input  logic              err_clear,
    output logic [FCNT_W-1:0] frame_count
);
    // state | meaning
    // IDLE  | no owner, arbitrating pending requests
    // BUSY  | owner granted, serializer shifting a frame
    // GAP   | mandatory idle time after a frame ends (done or abort)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             win;

`ifdef MATRIX_SCHED_FIXED_PRIO_EN
    always_comb begin
        win = !req[0];
    end
`else
    logic last;

    // Prefer the requester that did not own the previous frame.
    always_comb begin
        win = last;
        if (req[~last]) win = ~last;
    end

    always_ff @(posedge clk) begin
        if (reset) last <= 1'b1;
        else if (state == IDLE && req != 2'b00) last <= win;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 2'b00;
            req_done    <= 2'b00;
            ser_start   <= 1'b0;
            ser_abort   <= 1'b0;
            err_timeout <= 1'b0;
            frame_count <= '0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
        end else begin
            ser_start <= 1'b0;
            ser_abort <= 1'b0;
            req_done  <= 2'b00;
            if (err_clear) err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        grant     <= win ? 2'b10 : 2'b01;
                        ser_start <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // A done in the start cycle belongs to no frame of ours; done beats timeout.
                    if (!ser_start && ser_done) begin
                        grant       <= 2'b00;
                        req_done    <= grant;
                        frame_count <= frame_count + FCNT_W'(1);
                        gap_cnt     <= GAP_W'(GAP_CYCLES);
                        state       <= GAP;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        grant       <= 2'b00;
                        ser_abort   <= 1'b1;
                        err_timeout <= 1'b1;
                        gap_cnt     <= GAP_W'(GAP_CYCLES);
                        state       <= GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else gap_cnt <= gap_cnt - GAP_W'(1);
                end
                default: begin
                    grant <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// Directed bench for matrix_frame_scheduler: arbitration, gap, timeout/abort, reset, counter wrap.
// Honours MATRIX_SCHED_FIXED_PRIO_EN for the expected grant order.
module tb_matrix_frame_scheduler;
    localparam int FCNT_W = 8;

    logic              clk;
    logic              reset;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic [1:0]        req_done;
    logic              ser_start;
    logic              ser_done;
    logic              ser_abort;
    logic              err_timeout;
    logic              err_clear;
    logic [FCNT_W-1:0] frame_count;

    int vectors = 0;
    int miscompares = 0;

    matrix_frame_scheduler #(
        .GAP_CYCLES(16),
        .TIMEOUT_CYCLES(8192),
        .FCNT_W(FCNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .grant(grant),
        .req_done(req_done),
        .ser_start(ser_start),
        .ser_done(ser_done),
        .ser_abort(ser_abort),
        .err_timeout(err_timeout),
        .err_clear(err_clear),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (ser_start !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check("start_seen", {31'b0, ser_start}, 32'd1);
    endtask

    task automatic run_frame(input int d, output logic [1:0] g, output logic [1:0] rd);
        int n;
        wait_start(n);
        g = grant;
        repeat (d - 1) tick();
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        rd = req_done;
    endtask

    initial begin
        int n;
        logic seen;
        logic [1:0] g, rd;
        logic [1:0] exp_g [4];
`ifdef MATRIX_SCHED_FIXED_PRIO_EN
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        reset = 1'b1; req = 2'b00; ser_done = 1'b0; err_clear = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_grant", {30'b0, grant}, 32'd0);
        check("rst_start", {31'b0, ser_start}, 32'd0);
        check("rst_req_done", {30'b0, req_done}, 32'd0);
        check("rst_abort", {31'b0, ser_abort}, 32'd0);
        check("rst_err", {31'b0, err_timeout}, 32'd0);
        check("rst_fcnt", {24'b0, frame_count}, 32'd0);

        // Single frame from requester 0, done 10 cycles after start
        req = 2'b01;
        wait_start(n);
        check("t1_start_lat", n, 32'd1);
        check("t1_grant", {30'b0, grant}, 32'h1);
        tick();
        check("t1_start_pulse", {31'b0, ser_start}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("t1_grant_hold", {30'b0, grant}, 32'h1);
            tick();
        end
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        check("t1_req_done", {30'b0, req_done}, 32'h1);
        check("t1_grant_rel", {30'b0, grant}, 32'd0);
        check("t1_fcnt", {24'b0, frame_count}, 32'd1);
        check("t1_no_abort", {31'b0, ser_abort}, 32'd0);
        tick();
        check("t1_done_pulse", {30'b0, req_done}, 32'd0);
        wait_start(n);
        check("t1_gap_17_18", {31'b0, (n + 1 >= 17) && (n + 1 <= 18)}, 32'd1);
        repeat (4) tick();
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        req = 2'b00;
        check("t1_fcnt2", {24'b0, frame_count}, 32'd2);

        // Both requesting for four frames after a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t2_rst_fcnt", {24'b0, frame_count}, 32'd0);
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            run_frame(5, g, rd);
            check("t2_grant", {30'b0, g}, {30'b0, exp_g[i]});
            check("t2_req_done", {30'b0, rd}, {30'b0, exp_g[i]});
        end
        req = 2'b00;
        check("t2_fcnt", {24'b0, frame_count}, 32'd4);

        // Reset mid-BUSY, then stray done pulses
        req = 2'b01;
        wait_start(n);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 2'b00;
        check("t5_grant", {30'b0, grant}, 32'd0);
        check("t5_req_done", {30'b0, req_done}, 32'd0);
        check("t5_abort", {31'b0, ser_abort}, 32'd0);
        check("t5_fcnt", {24'b0, frame_count}, 32'd0);
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        check("t5_idle_done", {30'b0, req_done}, 32'd0);
        tick();
        check("t5_idle_fcnt", {24'b0, frame_count}, 32'd0);
        check("t5_idle_grant", {30'b0, grant}, 32'd0);
        req = 2'b01;
        wait_start(n);
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        check("t6_startdone_grant", {30'b0, grant}, 32'h1);
        check("t6_startdone_rd", {30'b0, req_done}, 32'd0);
        repeat (3) tick();
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        req = 2'b00;
        check("t6_late_done", {30'b0, req_done}, 32'h1);
        check("t6_fcnt", {24'b0, frame_count}, 32'd1);

        // Timeout with no done
        req = 2'b01;
        wait_start(n);
        n = 0;
        seen = 1'b0;
        while (ser_abort !== 1'b1 && n < 9000) begin
            tick();
            n++;
            if (req_done != 2'b00) seen = 1'b1;
        end
        check("t3_abort_lat", n, 32'd8192);
        check("t3_err", {31'b0, err_timeout}, 32'd1);
        check("t3_grant", {30'b0, grant}, 32'd0);
        check("t3_no_done", {31'b0, seen}, 32'd0);
        check("t3_fcnt", {24'b0, frame_count}, 32'd1);
        req = 2'b00;
        tick();
        check("t3_abort_pulse", {31'b0, ser_abort}, 32'd0);
        check("t3_err_sticky", {31'b0, err_timeout}, 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("t3_err_clr", {31'b0, err_timeout}, 32'd0);

        // Timeout while err_clear held: set wins on the abort edge
        req = 2'b01;
        err_clear = 1'b1;
        wait_start(n);
        repeat (8192) tick();
        check("t3b_abort", {31'b0, ser_abort}, 32'd1);
        check("t3b_set_wins", {31'b0, err_timeout}, 32'd1);
        tick();
        err_clear = 1'b0;
        req = 2'b00;
        check("t3b_cleared", {31'b0, err_timeout}, 32'd0);

        // Done in the timeout cycle
        req = 2'b01;
        wait_start(n);
        repeat (8191) tick();
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        req = 2'b00;
        check("t4_req_done", {30'b0, req_done}, 32'h1);
        check("t4_no_abort", {31'b0, ser_abort}, 32'd0);
        check("t4_no_err", {31'b0, err_timeout}, 32'd0);
        check("t4_fcnt", {24'b0, frame_count}, 32'd2);

        // Counter wrap (8-bit instance): 2 -> 255 -> 0
        req = 2'b01;
        for (int i = 0; i < 253; i++) run_frame(2, g, rd);
        check("t6_fcnt_max", {24'b0, frame_count}, 32'd255);
        run_frame(2, g, rd);
        req = 2'b00;
        check("t6_wrap_rd", {30'b0, rd}, 32'h1);
        check("t6_fcnt_wrap", {24'b0, frame_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
